mouse_cfg_ctrl: RTL and testbench
=================================

Name: mouse_cfg_ctrl

Overview:
- Sequences the configuration port of the PS/2 mouse controller (value bus plus setmax_x / setmax_y / setx / sety strobes) in the clk100MHz domain.
- After reset it waits a start-up delay, then programs the cursor limits and the initial position.
- After that it serves runtime position-load requests: warp to a given x/y, or recenter to the initial position.
- Lets the game logic reposition the cursor without touching the mouse controller directly.

Parameters:
- MAX_X, 799, x limit written via setmax_x (12-bit value)
- MAX_Y, 599, y limit written via setmax_y (12-bit value)
- INIT_X, 400, x position written at init and on recenter
- INIT_Y, 300, y position written at init and on recenter
- STARTUP_CYCLES, 1000, idle cycles after reset before the first strobe (>=1)
- GAP_CYCLES, 4, strobe-free cycles after each strobe (>=1)

Ports:
- clk100MHz  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- warp_req  input  1  one-cycle request to load warp_x/warp_y
- warp_x  input  12  target x, sampled with warp_req
- warp_y  input  12  target y, sampled with warp_req
- recenter_req  input  1  one-cycle request to load INIT_X/INIT_Y
- value  output  12  data bus to mouse controller
- setmax_x  output  1  one-cycle strobe, value is max x
- setmax_y  output  1  one-cycle strobe, value is max y
- setx  output  1  one-cycle strobe, value is x position
- sety  output  1  one-cycle strobe, value is y position
- busy  output  1  high while a sequence is pending or running
- init_done  output  1  level, high once the init sequence completes
- done  output  1  one-cycle pulse on completion of any sequence

Behaviour:
- All outputs are registered.
- Reset values:
  - value = 0
  - setmax_x, setmax_y, setx, sety = 0
  - busy = 1
  - init_done = 0
  - done = 0
- FSM states: WAIT, SMAXX, SMAXY, SX, SY, GAP, IDLE. GAP remembers its successor state.
- WAIT:
  - The counter counts STARTUP_CYCLES edges with rst=0. Call the first such edge E0.
  - setmax_x=1 and value=MAX_X during the cycle after edge E0+STARTUP_CYCLES-1.
- Init order: SMAXX, GAP, SMAXY, GAP, SX (INIT_X), GAP, SY (INIT_Y), GAP, IDLE.
- Strobe and gap timing:
  - Each strobe is high exactly one cycle.
  - value is valid in the strobe cycle and held through the following gap.
  - Consecutive strobes are GAP_CYCLES+1 cycles apart.
  - At most one strobe is high in any cycle.
- Entering IDLE:
  - done=1 for one cycle and busy=0 in that same cycle.
  - At the end of init only, init_done is set and stays 1 until rst.
- Request handling in IDLE:
  - Requests are sampled only in IDLE.
  - warp_req has priority over recenter_req; a simultaneous recenter_req is dropped.
  - If a request is sampled at edge Ek, then from Ek: state=SX, setx=1, busy=1.
  - value = min(warp_x, MAX_X) for a warp, INIT_X for a recenter.
  - warp_y is captured at Ek.
  - Sequence: SX, GAP, SY (min(warp_y, MAX_Y) or INIT_Y), GAP, IDLE with a done pulse.
  - Total request-to-done latency: 2*(GAP_CYCLES+1) cycles.
- Requests arriving while busy=1, including during init, are ignored and are not queued.
- Comparisons for clamping are unsigned 12-bit; values equal to the limit pass unchanged.
- rst asserted in any state:
  - At the next edge all outputs return to reset values, init_done clears, and the FSM goes to WAIT.
  - The full init sequence reruns.
- Counters are sized from max(STARTUP_CYCLES, GAP_CYCLES) and must never wrap in normal operation.

Test Plan:
1. Reset, then release with STARTUP_CYCLES=10, GAP_CYCLES=2 -> setmax_x(799) at cycle 10, setmax_y(599) at 13, setx(400) at 16, sety(300) at 19. done pulse and init_done=1 at 22. busy falls in the same cycle as done.
2. After init, warp_req with x=100, y=50 -> setx with value=100 the next cycle, sety with value=50 three cycles later. done after 6 cycles total.
3. warp_req with x=1000, y=4095 -> value 799 on setx, 599 on sety.
4. warp_req and recenter_req in the same cycle -> only the warp runs. A recenter_req during that sequence is ignored: no further setx after done.
5. recenter_req in IDLE -> setx 400, sety 300, done. Requests held high during init produce no extra strobes.
6. rst asserted in the cycle of setmax_y during init -> all strobes 0 and init_done 0 at the next edge. After release the init sequence restarts from WAIT with the full timing of scenario 1.

Source files
------------

// File: rtl/mouse_cfg_ctrl.sv
// Configuration sequencer for the PS/2 mouse controller: programs the cursor limits and initial position after a start-up delay, then serves warp/recenter position loads.
// Latency: first strobe STARTUP_CYCLES edges after reset release; strobes GAP_CYCLES+1 apart; request-to-done 2*(GAP_CYCLES+1) cycles.
// Backpressure: none; requests arriving while busy are dropped, not queued.
//
// Ports: clk100MHz/rst (sync, active-high); warp_req + warp_x/warp_y and recenter_req in;
//        value bus with setmax_x/setmax_y/setx/sety strobes, busy, init_done, done out. All outputs registered.
module mouse_cfg_ctrl #(
  parameter int MAX_X          = 799,
  parameter int MAX_Y          = 599,
  parameter int INIT_X         = 400,
  parameter int INIT_Y         = 300,
  parameter int STARTUP_CYCLES = 1000,
  parameter int GAP_CYCLES     = 4
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        warp_req,
  input  logic [11:0] warp_x,
  input  logic [11:0] warp_y,
  input  logic        recenter_req,
  output logic [11:0] value,
  output logic        setmax_x,
  output logic        setmax_y,
  output logic        setx,
  output logic        sety,
  output logic        busy,
  output logic        init_done,
  output logic        done
);

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_SMAXX = 3'd1;
  localparam logic [2:0] S_SMAXY = 3'd2;
  localparam logic [2:0] S_SX    = 3'd3;
  localparam logic [2:0] S_SY    = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;

  // One counter serves both the start-up wait and the inter-strobe gap;
  // it only ever reaches (limit-1), so it cannot wrap.
  localparam int CMAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [11:0] MAX_X12  = 12'(MAX_X);
  localparam logic [11:0] MAX_Y12  = 12'(MAX_Y);
  localparam logic [11:0] INIT_X12 = 12'(INIT_X);
  localparam logic [11:0] INIT_Y12 = 12'(INIT_Y);
  localparam logic [CW-1:0] WAIT_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    succ_q, succ_d;      // state entered when the current gap expires
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   value_q, value_d;
  logic [11:0]   y_q, y_d;            // y value for the pending SY strobe
  logic          setmax_x_q, setmax_x_d;
  logic          setmax_y_q, setmax_y_d;
  logic          setx_q, setx_d;
  logic          sety_q, sety_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    succ_d      = succ_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    y_d         = y_q;
    setmax_x_d  = 1'b0;
    setmax_y_d  = 1'b0;
    setx_d      = 1'b0;
    sety_d      = 1'b0;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    done_d      = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_SMAXX;
          setmax_x_d = 1'b1;
          value_d    = MAX_X12;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Each strobe state lasts one cycle, then hands over to GAP with its successor.
      S_SMAXX: begin state_d = S_GAP; succ_d = S_SMAXY; cnt_d = '0; end
      S_SMAXY: begin state_d = S_GAP; succ_d = S_SX;    cnt_d = '0; end
      S_SX:    begin state_d = S_GAP; succ_d = S_SY;    cnt_d = '0; end
      S_SY:    begin state_d = S_GAP; succ_d = S_IDLE;  cnt_d = '0; end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = succ_q;
          case (succ_q)
            S_SMAXY: begin setmax_y_d = 1'b1; value_d = MAX_Y12;  end
            S_SX:    begin setx_d     = 1'b1; value_d = INIT_X12; end // only reached during init
            S_SY:    begin sety_d     = 1'b1; value_d = y_q;      end
            default: begin
              // Completion of init or of a request: setting init_done again is harmless.
              done_d      = 1'b1;
              busy_d      = 1'b0;
              init_done_d = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (warp_req) begin
          state_d = S_SX;
          setx_d  = 1'b1;
          busy_d  = 1'b1;
          value_d = (warp_x > MAX_X12) ? MAX_X12 : warp_x;
          y_d     = (warp_y > MAX_Y12) ? MAX_Y12 : warp_y;
        end else if (recenter_req) begin
          state_d = S_SX;
          setx_d  = 1'b1;
          busy_d  = 1'b1;
          value_d = INIT_X12;
          y_d     = INIT_Y12;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state_q     <= S_WAIT;
      succ_q      <= S_IDLE;
      cnt_q       <= '0;
      value_q     <= '0;
      y_q         <= INIT_Y12;
      setmax_x_q  <= 1'b0;
      setmax_y_q  <= 1'b0;
      setx_q      <= 1'b0;
      sety_q      <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      succ_q      <= succ_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      y_q         <= y_d;
      setmax_x_q  <= setmax_x_d;
      setmax_y_q  <= setmax_y_d;
      setx_q      <= setx_d;
      sety_q      <= sety_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      done_q      <= done_d;
    end
  end

  assign value     = value_q;
  assign setmax_x  = setmax_x_q;
  assign setmax_y  = setmax_y_q;
  assign setx      = setx_q;
  assign sety      = sety_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mouse_cfg_ctrl.sv
// Directed bench for mouse_cfg_ctrl with STARTUP_CYCLES=10, GAP_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_mouse_cfg_ctrl;

  logic        clk100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        warp_req = 1'b0;
  logic [11:0] warp_x = '0;
  logic [11:0] warp_y = '0;
  logic        recenter_req = 1'b0;
  logic [11:0] value;
  logic        setmax_x, setmax_y, setx, sety, busy, init_done, done;

  int checks = 0;
  int errors = 0;

  mouse_cfg_ctrl #(
    .MAX_X(799), .MAX_Y(599), .INIT_X(400), .INIT_Y(300),
    .STARTUP_CYCLES(10), .GAP_CYCLES(2)
  ) dut (
    .clk100MHz(clk100MHz), .rst(rst),
    .warp_req(warp_req), .warp_x(warp_x), .warp_y(warp_y),
    .recenter_req(recenter_req),
    .value(value), .setmax_x(setmax_x), .setmax_y(setmax_y),
    .setx(setx), .sety(sety), .busy(busy), .init_done(init_done), .done(done)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic tick();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobes packed as {setmax_x, setmax_y, setx, sety}.
  function automatic logic [11:0] strobes();
    return {8'd0, setmax_x, setmax_y, setx, sety};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_value"}, value, 12'd0);
    chk({tag, "_strobes"}, strobes(), 12'd0);
    chk({tag, "_busy"}, {11'd0, busy}, 12'd1);
    chk({tag, "_init_done"}, {11'd0, init_done}, 12'd0);
    chk({tag, "_done"}, {11'd0, done}, 12'd0);
  endtask

  // Releases rst (called just after an edge) and follows the full init sequence.
  // k counts edges from E0 (the first edge with rst=0). Optionally holds both
  // requests high throughout init; they must have no effect.
  task automatic run_init(input string tag, input logic hold_reqs);
    logic [11:0] exp_stb;
    rst = 1'b0;
    warp_req = hold_reqs;
    recenter_req = hold_reqs;
    warp_x = 12'd5;
    warp_y = 12'd6;
    for (int k = 0; k <= 21; k++) begin
      tick();
      case (k)
        9:       exp_stb = 12'b1000;
        12:      exp_stb = 12'b0100;
        15:      exp_stb = 12'b0010;
        18:      exp_stb = 12'b0001;
        default: exp_stb = 12'b0000;
      endcase
      chk($sformatf("%s_stb_k%0d", tag, k), strobes(), exp_stb);
      chk($sformatf("%s_busy_k%0d", tag, k), {11'd0, busy}, {11'd0, (k < 21)});
      chk($sformatf("%s_done_k%0d", tag, k), {11'd0, done}, {11'd0, (k == 21)});
      chk($sformatf("%s_initdone_k%0d", tag, k), {11'd0, init_done}, {11'd0, (k == 21)});
      if (k == 9)  chk({tag, "_maxx_val"}, value, 12'd799);
      if (k == 10 || k == 11) chk($sformatf("%s_maxx_hold_k%0d", tag, k), value, 12'd799);
      if (k == 12) chk({tag, "_maxy_val"}, value, 12'd599);
      if (k == 15) chk({tag, "_initx_val"}, value, 12'd400);
      if (k == 18) chk({tag, "_inity_val"}, value, 12'd300);
    end
    warp_req = 1'b0;
    recenter_req = 1'b0;
  endtask

  // Issues a one-cycle request from IDLE and follows SX, GAP, SY, GAP, IDLE.
  // mid_recenter pulses recenter_req while the sequence is busy.
  task automatic run_req(input string tag, input logic w, input logic r,
                         input logic [11:0] x, input logic [11:0] y,
                         input logic [11:0] exp_x, input logic [11:0] exp_y,
                         input logic mid_recenter);
    logic [11:0] exp_stb;
    warp_req = w;
    recenter_req = r;
    warp_x = x;
    warp_y = y;
    tick();
    warp_req = 1'b0;
    recenter_req = 1'b0;
    warp_x = 12'hABC;   // changing after capture must not affect the y strobe
    warp_y = 12'hABC;
    chk({tag, "_setx_stb"}, strobes(), 12'b0010);
    chk({tag, "_setx_val"}, value, exp_x);
    chk({tag, "_busy0"}, {11'd0, busy}, 12'd1);
    chk({tag, "_done0"}, {11'd0, done}, 12'd0);
    for (int k = 1; k <= 6; k++) begin
      if (mid_recenter) recenter_req = (k == 2);
      tick();
      exp_stb = (k == 3) ? 12'b0001 : 12'b0000;
      chk($sformatf("%s_stb_k%0d", tag, k), strobes(), exp_stb);
      chk($sformatf("%s_busy_k%0d", tag, k), {11'd0, busy}, {11'd0, (k < 6)});
      chk($sformatf("%s_done_k%0d", tag, k), {11'd0, done}, {11'd0, (k == 6)});
      if (k < 3) chk($sformatf("%s_xhold_k%0d", tag, k), value, exp_x);
      if (k == 3) chk({tag, "_sety_val"}, value, exp_y);
    end
    recenter_req = 1'b0;
    chk({tag, "_initdone"}, {11'd0, init_done}, 12'd1);
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("%s_stb_k%0d", tag, k), strobes(), 12'd0);
      chk($sformatf("%s_busy_k%0d", tag, k), {11'd0, busy}, 12'd0);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");

    // Scenario 1: plain init
    run_init("init1", 1'b0);
    idle_quiet("idle1", 2);

    // Scenario 2: in-range warp
    run_req("warp1", 1'b1, 1'b0, 12'd100, 12'd50, 12'd100, 12'd50, 1'b0);
    // Scenario 3: clamped warp, and values exactly at the limits
    run_req("warp2", 1'b1, 1'b0, 12'd1000, 12'd4095, 12'd799, 12'd599, 1'b0);
    run_req("warp3", 1'b1, 1'b0, 12'd799, 12'd599, 12'd799, 12'd599, 1'b0);
    run_req("warp4", 1'b1, 1'b0, 12'd800, 12'd600, 12'd799, 12'd599, 1'b0);
    // Scenario 4: warp wins over simultaneous recenter; mid-sequence recenter dropped
    run_req("both", 1'b1, 1'b1, 12'd7, 12'd9, 12'd7, 12'd9, 1'b1);
    idle_quiet("after_both", 4);
    // Scenario 5: recenter
    run_req("recenter", 1'b0, 1'b1, 12'd0, 12'd0, 12'd400, 12'd300, 1'b0);
    idle_quiet("after_rc", 2);

    // Scenario 6: reset during the setmax_y cycle of init
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) tick();
    chk("pre_rst_maxy", strobes(), 12'b0100);
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    // Rerun with requests held high during init: no extra strobes allowed
    run_init("init2", 1'b1);
    idle_quiet("idle2", 3);
    chk("final_initdone", {11'd0, init_done}, 12'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
